seq_frame_tx: RTL and testbench
===============================

Name: seq_frame_tx

Overview:
Serial frame transmitter, the transmit end of the serial sequence-detect link. It accepts a parallel payload word through a valid/ready handshake and prepends the sync header 1001. It shifts the header and payload out one bit per clock, MSB first, then holds the line low for a programmable inter-frame gap. Its output drives the ser_in of the overlapping 1001 Mealy detector on the receive side.

Parameters:
DATA_W, 8, payload width in bits; legal 1..32
SYNC_W, 4, sync header width in bits; legal 1..8
SYNC_PAT, 4'b1001, sync header value, sent MSB first
GAP_CYC, 2, idle cycles (line low) after each frame; legal 1..15

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
load_valid  input  1  payload offered
load_data  input  DATA_W  payload word
load_ready  output  1  transmitter can accept a payload
ser_out  output  1  serial line to detector ser_in
ser_en  output  1  high while ser_out carries a frame bit
busy  output  1  high from payload accept until return to IDLE
frame_done  output  1  one-cycle pulse, first gap cycle after last frame bit

Behaviour:
- Reset: clk and rst as stated above (synchronous, active-high). Reset values: state=IDLE, ser_out=0, ser_en=0, busy=0, frame_done=0, load_ready=1, shift register and counters cleared.
- Reset wins over every other input in the same cycle.
- Reset mid-frame aborts the frame immediately. The line goes low on the next cycle and the partial frame is not resent.
- All outputs are registered, except load_ready = (state==IDLE) & ~rst.
- Handshake: a transfer occurs on an edge where load_valid & load_ready. load_data is captured on that edge. load_valid while busy is ignored, with no queueing.
- States: IDLE, SYNC, DATA, GAP (plus PAR, see Optional Feature).
- IDLE: ser_out=0, ser_en=0. On transfer, go to SYNC. Counters: bit counter=SYNC_W-1.
- Latency: the first header bit appears on ser_out in the cycle right after the accept edge.
- SYNC: ser_out=SYNC_PAT[cnt], ser_en=1. When cnt==0, go to DATA with cnt=DATA_W-1. Otherwise decrement cnt.
- DATA: ser_out=payload[cnt], MSB first, ser_en=1. When cnt==0, go to GAP (or PAR). Otherwise decrement cnt.
- GAP: ser_out=0, ser_en=0, busy=1 for exactly GAP_CYC cycles. frame_done=1 only in the first GAP cycle. After GAP_CYC cycles, go to IDLE.
- Frame length: SYNC_W+DATA_W bits (+1 with parity).
- Frame period with continuous load_valid: SYNC_W+DATA_W+GAP_CYC+1 cycles. This is the frame bits, the gap, and one IDLE accept cycle.
- The payload is not scrubbed for sync aliases. The sender owns payload choice, and payload bits may contain 1001.
- Counter widths: the counter is wide enough for max(SYNC_W,DATA_W)-1 and GAP_CYC, with no wrap inside legal ranges.

Optional Feature:
PARITY_EN_EN is not used. The macro is FRAME_PARITY_EN.
- Defined: state PAR follows DATA for one cycle. ser_out = even parity (XOR) over the DATA_W payload bits, ser_en=1. Then GAP. Frame length becomes SYNC_W+DATA_W+1.
- Undefined: PAR state and parity logic are absent. DATA goes directly to GAP.

Test Plan:
- Reset check: assert rst 3 cycles with load_valid=1 -> ser_out=0, ser_en=0, busy=0, frame_done=0, load_ready=0 during rst; load_ready=1 after rst released.
- Single frame: load 0xA5 -> starting the cycle after accept, ser_out = 1,0,0,1,1,0,1,0,0,1,0,1 with ser_en=1 for 12 cycles. Then 2 gap cycles with ser_out=0, frame_done=1 in gap cycle 1. load_ready=1 on cycle 15 after accept.
- Busy ignore: during the frame for 0x0F, pulse load_valid with 0xFF -> the transmitted payload stays 00001111 and no second frame is sent.
- Back-to-back: hold load_valid=1 with 0x3C then 0xC3 -> the second header starts exactly 15 cycles after the first. Payload bits are 00111100 then 11000011.
- Reset mid-frame: assert rst on the 3rd payload bit of 0xFF -> ser_out=0 and ser_en=0 from the next cycle, state IDLE, no frame_done pulse.
- Loopback with detector: send 0x00 -> detector out pulses exactly once, the cycle after the 4th header bit is sampled. With FRAME_PARITY_EN, 0xA5 gives parity bit 0 and 0x07 gives 1.

Source files
------------

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync header + payload shifted out MSB first, then a low gap.
// Optional trailing even-parity bit when FRAME_PARITY_EN is defined.
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(4'b1001),
  parameter int                GAP_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              ser_out,
  output logic              ser_en,
  output logic              busy,
  output logic              frame_done
);

  // Handshake: a payload transfer happens on a rising edge where load_valid and
  // load_ready are both high; load_valid is ignored whenever load_ready is low.

  localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W - 1 : DATA_W - 1;
  localparam int MAXV   = (MAX_SD > GAP_CYC) ? MAX_SD : GAP_CYC;
  localparam int CW     = $clog2(MAXV + 1);

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SYNC = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
`ifdef FRAME_PARITY_EN
  localparam logic [2:0] PAR  = 3'd4;
  logic par_bit;
`endif

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [SYNC_W-1:0] sync_sr;
  logic [DATA_W-1:0] data_sr;

  assign load_ready = (state == IDLE) & ~rst;

  // Outputs are registered, so each branch loads the bit for the cycle it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sync_sr    <= '0;
      data_sr    <= '0;
      ser_out    <= 1'b0;
      ser_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FRAME_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ser_out    <= 1'b0;
          ser_en     <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          cnt        <= SYNC_LAST;
          if (load_valid && load_ready) begin
            state   <= SYNC;
            sync_sr <= SYNC_PAT << 1;
            data_sr <= load_data;
            ser_out <= SYNC_PAT[SYNC_W-1];
            ser_en  <= 1'b1;
            busy    <= 1'b1;
`ifdef FRAME_PARITY_EN
            par_bit <= ^load_data;
`endif
          end
        end
        SYNC: begin
          if (cnt == '0) begin
            state   <= DATA;
            cnt     <= DATA_LAST;
            ser_out <= data_sr[DATA_W-1];
            data_sr <= data_sr << 1;
          end else begin
            cnt     <= cnt - CW'(1);
            ser_out <= sync_sr[SYNC_W-1];
            sync_sr <= sync_sr << 1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
`ifdef FRAME_PARITY_EN
            state   <= PAR;
            ser_out <= par_bit;
`else
            state      <= GAP;
            cnt        <= GAP_LAST;
            ser_out    <= 1'b0;
            ser_en     <= 1'b0;
            frame_done <= 1'b1;
`endif
          end else begin
            cnt     <= cnt - CW'(1);
            ser_out <= data_sr[DATA_W-1];
            data_sr <= data_sr << 1;
          end
        end
`ifdef FRAME_PARITY_EN
        PAR: begin
          state      <= GAP;
          cnt        <= GAP_LAST;
          ser_out    <= 1'b0;
          ser_en     <= 1'b0;
          frame_done <= 1'b1;
        end
`endif
        GAP: begin
          frame_done <= 1'b0;
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= SYNC_LAST;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ser_out <= 1'b0;
          ser_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: per-scenario tasks compared against a cycle-indexed frame model.
// Build with +define+FRAME_PARITY_EN to cover the parity bit.
module tb_seq_frame_tx;
  localparam int DATA_W  = 8;
  localparam int SYNC_W  = 4;
  localparam int GAP_CYC = 2;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1001;
`ifdef FRAME_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FL = SYNC_W + DATA_W + PAR_W;
  localparam int NC = FL + GAP_CYC + 1;

  logic clk = 1'b0;
  logic rst, load_valid, load_ready, ser_out, ser_en, busy, frame_done;
  logic [DATA_W-1:0] load_data;

  int checks = 0;
  int failures = 0;

  logic [63:0] obs_ser, obs_en, obs_fd, obs_busy, obs_rdy;
  logic [63:0] exp_ser, exp_en, exp_fd, exp_busy, exp_rdy, mask;

  always #5 clk = ~clk;

  seq_frame_tx #(
    .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .ser_out(ser_out), .ser_en(ser_en),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for load_ready, then offers d for one edge.
  task automatic accept(input logic [DATA_W-1:0] d);
    int n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait: load_ready=%b required 1", load_ready);
    end
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  // Records w cycles of outputs (cycle 0 = first cycle after accept);
  // load_valid is driven high with data d for cycles v_from..v_to-1.
  task automatic capture(input int w, input int v_from, input int v_to,
                         input logic [DATA_W-1:0] d);
    obs_ser = '0; obs_en = '0; obs_fd = '0; obs_busy = '0; obs_rdy = '0;
    for (int i = 0; i < w; i++) begin
      obs_ser[i]  = ser_out;
      obs_en[i]   = ser_en;
      obs_fd[i]   = frame_done;
      obs_busy[i] = busy;
      obs_rdy[i]  = load_ready;
      load_valid  = (i >= v_from && i < v_to);
      load_data   = d;
      step();
    end
    load_valid = 1'b0;
    mask = (64'd1 << w) - 64'd1;
  endtask

  task automatic model_clear();
    exp_ser = '0; exp_en = '0; exp_fd = '0; exp_busy = '0; exp_rdy = '0;
  endtask

  // One frame starting at cycle off: header, payload MSB first, optional parity, gap.
  task automatic model_frame(input logic [DATA_W-1:0] p, input int off);
    logic [SYNC_W-1:0] sp;
    sp = SYNC_PAT;
    for (int i = 0; i < SYNC_W; i++) exp_ser[off + i] = sp[SYNC_W-1-i];
    for (int i = 0; i < DATA_W; i++) exp_ser[off + SYNC_W + i] = p[DATA_W-1-i];
`ifdef FRAME_PARITY_EN
    exp_ser[off + SYNC_W + DATA_W] = ^p;
`endif
    for (int i = 0; i < FL; i++) exp_en[off + i] = 1'b1;
    exp_fd[off + FL] = 1'b1;
    for (int i = 0; i < FL + GAP_CYC; i++) exp_busy[off + i] = 1'b1;
    exp_rdy = ~exp_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hA5;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ser_out !== 1'b0) begin failures++; $display("FAIL reset_ser_out: got %b want 0", ser_out); end
      checks++; if (ser_en !== 1'b0) begin failures++; $display("FAIL reset_ser_en: got %b want 0", ser_en); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
      if (i < 2) step();
    end
    rst = 1'b0;
    load_valid = 1'b0;
    #1;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", load_ready); end
    step();
    checks++; if (ser_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_release_idle: ser_en=%b busy=%b want 0 0", ser_en, busy); end
  endtask

  task automatic test_single_frame();
    model_clear();
    model_frame(8'hA5, 0);
    accept(8'hA5);
    capture(NC + 2, 0, 0, '0);
    checks++; if ((obs_ser & mask) !== (exp_ser & mask)) begin failures++; $display("FAIL single_ser: got %h want %h", obs_ser & mask, exp_ser & mask); end
    checks++; if ((obs_en & mask) !== (exp_en & mask)) begin failures++; $display("FAIL single_en: got %h want %h", obs_en & mask, exp_en & mask); end
    checks++; if ((obs_fd & mask) !== (exp_fd & mask)) begin failures++; $display("FAIL single_fd: got %h want %h", obs_fd & mask, exp_fd & mask); end
    checks++; if ((obs_busy & mask) !== (exp_busy & mask)) begin failures++; $display("FAIL single_busy: got %h want %h", obs_busy & mask, exp_busy & mask); end
    checks++; if ((obs_rdy & mask) !== (exp_rdy & mask)) begin failures++; $display("FAIL single_ready: got %h want %h", obs_rdy & mask, exp_rdy & mask); end
  endtask

  task automatic test_busy_ignore();
    model_clear();
    model_frame(8'h0F, 0);
    accept(8'h0F);
    capture(NC + 6, 3, 4, 8'hFF);
    checks++; if ((obs_ser & mask) !== (exp_ser & mask)) begin failures++; $display("FAIL busy_ignore_ser: got %h want %h", obs_ser & mask, exp_ser & mask); end
    checks++; if ((obs_en & mask) !== (exp_en & mask)) begin failures++; $display("FAIL busy_ignore_en: got %h want %h", obs_en & mask, exp_en & mask); end
    checks++; if ((obs_busy & mask) !== (exp_busy & mask)) begin failures++; $display("FAIL busy_ignore_busy: got %h want %h", obs_busy & mask, exp_busy & mask); end
    checks++; if ((obs_fd & mask) !== (exp_fd & mask)) begin failures++; $display("FAIL busy_ignore_fd: got %h want %h", obs_fd & mask, exp_fd & mask); end
  endtask

  task automatic test_back_to_back();
    model_clear();
    model_frame(8'h3C, 0);
    model_frame(8'hC3, NC);
    accept(8'h3C);
    capture(2 * NC + 2, 0, NC, 8'hC3);
    checks++; if ((obs_ser & mask) !== (exp_ser & mask)) begin failures++; $display("FAIL b2b_ser: got %h want %h", obs_ser & mask, exp_ser & mask); end
    checks++; if ((obs_en & mask) !== (exp_en & mask)) begin failures++; $display("FAIL b2b_en: got %h want %h", obs_en & mask, exp_en & mask); end
    checks++; if ((obs_fd & mask) !== (exp_fd & mask)) begin failures++; $display("FAIL b2b_fd: got %h want %h", obs_fd & mask, exp_fd & mask); end
    checks++; if ((obs_busy & mask) !== (exp_busy & mask)) begin failures++; $display("FAIL b2b_busy: got %h want %h", obs_busy & mask, exp_busy & mask); end
    checks++; if ((obs_rdy & mask) !== (exp_rdy & mask)) begin failures++; $display("FAIL b2b_ready: got %h want %h", obs_rdy & mask, exp_rdy & mask); end
  endtask

  task automatic test_reset_mid_frame();
    int fd_seen = 0;
    int en_seen = 0;
    accept(8'hFF);
    for (int i = 0; i < SYNC_W + 2; i++) step();
    checks++; if (ser_out !== 1'b1 || ser_en !== 1'b1) begin failures++; $display("FAIL midrst_pre: ser_out=%b ser_en=%b want 1 1", ser_out, ser_en); end
    rst = 1'b1;
    step();
    checks++; if (ser_out !== 1'b0 || ser_en !== 1'b0) begin failures++; $display("FAIL midrst_line: ser_out=%b ser_en=%b want 0 0", ser_out, ser_en); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL midrst_flags: busy=%b frame_done=%b want 0 0", busy, frame_done); end
    rst = 1'b0;
    #1;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL midrst_idle: load_ready=%b want 1", load_ready); end
    for (int i = 0; i < 20; i++) begin
      if (frame_done === 1'b1) fd_seen++;
      if (ser_en === 1'b1) en_seen++;
      step();
    end
    checks++; if (fd_seen != 0) begin failures++; $display("FAIL midrst_no_done: pulses=%0d want 0", fd_seen); end
    checks++; if (en_seen != 0) begin failures++; $display("FAIL midrst_no_resend: ser_en cycles=%0d want 0", en_seen); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] p;
    int r;
    for (int n = 0; n < 20; n++) begin
      p = DATA_W'($urandom);
      r = $urandom_range(0, 3);
      for (int k = 0; k < r; k++) step();
      model_clear();
      model_frame(p, 0);
      accept(p);
      r = $urandom_range(0, NC - 2);
      capture(NC + 1, r, r + 1, ~p);
      checks++; if ((obs_ser & mask) !== (exp_ser & mask)) begin failures++; $display("FAIL rand_ser p=%h: got %h want %h", p, obs_ser & mask, exp_ser & mask); end
      checks++; if ((obs_en & mask) !== (exp_en & mask)) begin failures++; $display("FAIL rand_en p=%h: got %h want %h", p, obs_en & mask, exp_en & mask); end
      checks++; if ((obs_fd & mask) !== (exp_fd & mask)) begin failures++; $display("FAIL rand_fd p=%h: got %h want %h", p, obs_fd & mask, exp_fd & mask); end
      checks++; if ((obs_rdy & mask) !== (exp_rdy & mask)) begin failures++; $display("FAIL rand_ready p=%h: got %h want %h", p, obs_rdy & mask, exp_rdy & mask); end
    end
  endtask

  // Overlapping 1001 detector run over the observed line (preceded by idle zeros).
  task automatic test_loopback();
    logic [3:0] hist;
    int det_cnt;
    int det_pos;
    accept(8'h00);
    capture(NC + 1, 0, 0, '0);
    hist = '0;
    det_cnt = 0;
    det_pos = -1;
    for (int i = 0; i < NC + 1; i++) begin
      hist = {hist[2:0], obs_ser[i]};
      if (hist == 4'b1001) begin
        det_cnt++;
        det_pos = i + 1;
      end
    end
    checks++; if (det_cnt != 1) begin failures++; $display("FAIL loopback_count: got %0d want 1", det_cnt); end
    checks++; if (det_pos != SYNC_W) begin failures++; $display("FAIL loopback_pos: got %0d want %0d", det_pos, SYNC_W); end
`ifdef FRAME_PARITY_EN
    accept(8'hA5);
    capture(NC, 0, 0, '0);
    checks++; if (obs_ser[FL-1] !== 1'b0) begin failures++; $display("FAIL parity_a5: got %b want 0", obs_ser[FL-1]); end
    accept(8'h07);
    capture(NC, 0, 0, '0);
    checks++; if (obs_ser[FL-1] !== 1'b1) begin failures++; $display("FAIL parity_07: got %b want 1", obs_ser[FL-1]); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    test_reset();
    test_single_frame();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
